// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer
//   Front end for a 1-bit serial adder. It accepts an operand pair through a
//   valid/ready handshake. It then emits a one-cycle carry-clear strobe, and
//   after that streams the operands LSB-first, one bit pair per cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand pair on in_a/in_b is valid
//   in_ready   block can accept an operand pair this cycle (combinational)
//   in_a/in_b  WIDTH-bit operands, sampled on handshake
//   out_clr    carry-clear strobe for the adder (OR with rst at the adder)
//   out_valid  out_a/out_b carry an operand bit this cycle
//   out_a/b    current operand bits
//   out_first  current bit is bit 0
//   out_last   current bit is bit WIDTH-1
module serial_operand_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_clr,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             take;

    always_comb begin
        at_last  = (state == SHIFT) && (cnt == LAST);
        in_ready = !rst && ((state == IDLE) || at_last);
        take     = in_valid && in_ready;
    end

    // Outputs are registered one step ahead: the edge that enters a cycle
    // loads the values shown during that cycle. sh_a[0]/sh_b[0] always hold
    // the bit currently on out_a/out_b, so the next bit is taken from [1].
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            out_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_a     <= 1'b0;
            out_b     <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        sh_a    <= in_a;
                        sh_b    <= in_b;
                        out_clr <= 1'b1;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    cnt       <= '0;
                    out_valid <= 1'b1;
                    out_a     <= sh_a[0];
                    out_b     <= sh_b[0];
                    out_first <= 1'b1;
                    out_last  <= (LAST == '0);
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        cnt       <= cnt + CW'(1);
                        sh_a      <= sh_a >> 1;
                        sh_b      <= sh_b >> 1;
                        out_valid <= 1'b1;
                        out_a     <= sh_a[1];
                        out_b     <= sh_b[1];
                        out_last  <= ((cnt + CW'(1)) == LAST);
                    end else if (take) begin
                        // back-to-back: reload and clear with no IDLE gap
                        sh_a    <= in_a;
                        sh_b    <= in_b;
                        out_clr <= 1'b1;
                        state   <= CLEAR;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
